// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the fetch stage and its BTB.
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Upper bound on tag width; shorter tags are stored zero-extended.
    localparam int BTB_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_btb : direct-mapped branch target buffer, one lookup and one write port.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module fetch_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_word,
    output logic        hit,
    output logic [31:0] target,
    input  logic        we,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_target
);
    import fetch_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t           btb_mem [ENTRIES];
    btb_entry_t           rd_entry;
    logic [BTB_TAG_W-1:0] rd_tag;
    logic [BTB_TAG_W-1:0] wr_tag;

    assign rd_tag   = lookup_word >> IDX_W;
    assign wr_tag   = wr_word >> IDX_W;
    // Combinational read of the registered array: same-cycle writes are not visible.
    assign rd_entry = btb_mem[lookup_word[IDX_W-1:0]];
    assign hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign target   = rd_entry.target;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_mem[i].valid <= 1'b0;
            end
        end else if (we) begin
            btb_mem[wr_word[IDX_W-1:0]] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_fetch : PC owner, next-PC selection and imem request FSM feeding decode.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module stage_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        btbWe,
    input  logic [31:0] btbWPc,
    input  logic [31:0] btbWTarget,
    output logic [31:0] predPc,
    input  logic        predTaken,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic        fetchValid,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        bPredictedTakenF
);
    import fetch_pkg::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  hold_buf;
    logic [31:0]  hold_buf_next;
    logic [31:0]  seq_pc;
    logic [31:0]  next_pc;
    logic [31:0]  btb_target;
    logic         btb_hit;
    logic         pred_taken;
    logic         unused_bits;

    assign unused_bits = ^{redirectPc[1:0], btbWPc[1:0]};

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_word (pc[31:2]),
        .hit         (btb_hit),
        .target      (btb_target),
        .we          (btbWe),
        .wr_word     (btbWPc[31:2]),
        .wr_target   (btbWTarget)
    );

    assign seq_pc     = pc + 32'd4;
    assign pred_taken = predTaken & btb_hit;
    assign next_pc    = pred_taken ? btb_target : seq_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_REQ;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            hold_buf <= hold_buf_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        hold_buf_next = hold_buf;
        if (redirect) begin
            pc_next = {redirectPc[31:2], 2'b00};
            unique case (state)
                FS_REQ:   state_next = FS_DRAIN;
                FS_WAIT:  state_next = imemValid ? FS_REQ : FS_DRAIN;
                FS_HOLD:  state_next = FS_REQ;
                FS_DRAIN: state_next = imemValid ? FS_REQ : FS_DRAIN;
                default:  state_next = FS_REQ;
            endcase
        end else begin
            unique case (state)
                FS_REQ: state_next = FS_WAIT;
                FS_WAIT: begin
                    if (imemValid) begin
                        if (stall) begin
                            hold_buf_next = imemRdata;
                            state_next    = FS_HOLD;
                        end else begin
                            pc_next    = next_pc;
                            state_next = FS_REQ;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        pc_next    = next_pc;
                        state_next = FS_REQ;
                    end
                end
                FS_DRAIN: begin
                    if (imemValid) begin
                        state_next = FS_REQ;
                    end
                end
                default: state_next = FS_REQ;
            endcase
        end
    end

    always_comb begin
        imemReq          = 1'b0;
        fetchValid       = 1'b0;
        instrF           = NOP_INSTR;
        bPredictedTakenF = 1'b0;
        if (!rst) begin
            // A request issued alongside a redirect still goes out; it is drained later.
            imemReq    = (state == FS_REQ);
            fetchValid = !redirect && (((state == FS_WAIT) && imemValid) || (state == FS_HOLD));
            if (fetchValid) begin
                instrF           = (state == FS_HOLD) ? hold_buf : imemRdata;
                bPredictedTakenF = pred_taken;
            end
        end
    end

    assign imemAddr = pc;
    assign predPc   = pc;
    assign pcF      = pc;
    assign pcPlus4F = seq_pc;

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stage_fetch : scoreboard bench for stage_fetch with a variable-latency imem.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        btbWe;
    logic [31:0] btbWPc;
    logic [31:0] btbWTarget;
    logic [31:0] predPc;
    logic        predTaken;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic        fetchValid;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        bPredictedTakenF;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } fexp_t;

    logic [31:0] addr_q[$];
    fexp_t       fetch_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    logic        pred_en = 1'b0;

    assign predTaken = pred_en;

    always #5 clk = ~clk;

    stage_fetch #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirectPc       (redirectPc),
        .btbWe            (btbWe),
        .btbWPc           (btbWPc),
        .btbWTarget       (btbWTarget),
        .predPc           (predPc),
        .predTaken        (predTaken),
        .imemReq          (imemReq),
        .imemAddr         (imemAddr),
        .imemValid        (imemValid),
        .imemRdata        (imemRdata),
        .fetchValid       (fetchValid),
        .instrF           (instrF),
        .pcF              (pcF),
        .pcPlus4F         (pcPlus4F),
        .bPredictedTakenF (bPredictedTakenF)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h with no expectation queued", name, act);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_addr(input logic [31:0] a);
        addr_q.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] p, input logic pr);
        fexp_t e;
        e.pc   = p;
        e.pred = pr;
        fetch_q.push_back(e);
    endtask

    task automatic reset_dut;
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        btbWe    = 1'b0;
        @(negedge clk);
        check32("rst_imemReq", {31'b0, imemReq}, 32'd0);
        check32("rst_fetchValid", {31'b0, fetchValid}, 32'd0);
        check32("rst_instrF", instrF, NOP);
        check32("rst_bPred", {31'b0, bPredictedTakenF}, 32'd0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic end_test(input string name);
        check32({name, "_addr_left"}, addr_q.size(), 32'd0);
        check32({name, "_fetch_left"}, fetch_q.size(), 32'd0);
        addr_q.delete();
        fetch_q.delete();
    endtask

    // Memory model: latency counted from the request cycle to the valid cycle.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    logic        s_rst;
    logic        s_req;
    logic [31:0] s_addr;
    initial begin
        imemValid = 1'b0;
        imemRdata = '0;
        m_busy    = 1'b0;
        m_cnt     = 0;
        m_addr    = '0;
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_req  = imemReq;
            s_addr = imemAddr;
            @(posedge clk);
            #1;
            imemValid = 1'b0;
            if (s_rst) begin
                m_busy = 1'b0;
            end else begin
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        imemValid = 1'b1;
                        imemRdata = mem_word(m_addr);
                        m_busy    = 1'b0;
                    end
                end
                if (s_req) begin
                    if (lat <= 1) begin
                        imemValid = 1'b1;
                        imemRdata = mem_word(s_addr);
                    end else begin
                        m_busy = 1'b1;
                        m_cnt  = lat - 1;
                        m_addr = s_addr;
                    end
                end
            end
        end
    end

    // Monitor: compares every request and every accepted fetch against the queues.
    initial begin
        fexp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (imemReq) begin
                    if (addr_q.size() == 0) fail_now("unexpected_req", imemAddr);
                    else check32("imemAddr", imemAddr, addr_q.pop_front());
                end
                if (fetchValid && !stall) begin
                    if (fetch_q.size() == 0) begin
                        fail_now("unexpected_fetch", pcF);
                    end else begin
                        e = fetch_q.pop_front();
                        check32("pcF", pcF, e.pc);
                        check32("instrF", instrF, mem_word(e.pc));
                        check32("pcPlus4F", pcPlus4F, e.pc + 32'd4);
                        check32("predPc", predPc, e.pc);
                        check32("bPred", {31'b0, bPredictedTakenF}, {31'b0, e.pred});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redirectPc = '0;
        btbWPc     = '0;
        btbWTarget = '0;

        // Sequential fetch, 1-cycle memory.
        lat = 1; pred_en = 1'b0;
        reset_dut;
        push_addr(32'h0); push_addr(32'h4); push_addr(32'h8);
        push_fetch(32'h0, 1'b0); push_fetch(32'h4, 1'b0); push_fetch(32'h8, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check32("fv_pattern", {31'b0, fetchValid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick;
        end
        end_test("seq");

        // Stall held for 3 cycles across the response.
        lat = 1;
        reset_dut;
        push_addr(32'h0); push_addr(32'h4);
        push_fetch(32'h0, 1'b0); push_fetch(32'h4, 1'b0);
        tick;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("stall_fv", {31'b0, fetchValid}, 32'd1);
            check32("stall_instr", instrF, mem_word(32'h0));
            check32("stall_pcF", pcF, 32'h0);
            check32("stall_noreq", {31'b0, imemReq}, 32'd0);
            tick;
        end
        stall = 1'b0;
        tick; tick; tick;
        end_test("stall");

        // BTB hit with predTaken=1 and then with predTaken=0.
        for (int p = 1; p >= 0; p--) begin
            lat = 1; pred_en = (p == 1);
            reset_dut;
            btbWe = 1'b1; btbWPc = 32'h10; btbWTarget = 32'h40;
            push_addr(32'h0); push_addr(32'h4); push_addr(32'h8); push_addr(32'hC); push_addr(32'h10);
            push_addr((p == 1) ? 32'h40 : 32'h14);
            push_fetch(32'h0, 1'b0); push_fetch(32'h4, 1'b0); push_fetch(32'h8, 1'b0);
            push_fetch(32'hC, 1'b0); push_fetch(32'h10, p == 1);
            push_fetch((p == 1) ? 32'h40 : 32'h14, 1'b0);
            tick;
            btbWe = 1'b0;
            repeat (11) tick;
            end_test("btb");
        end

        // Redirect in FS_WAIT with 4-cycle memory: drain the stale response.
        lat = 4; pred_en = 1'b0;
        reset_dut;
        push_addr(32'h0); push_addr(32'h80);
        push_fetch(32'h80, 1'b0);
        tick;
        redirect = 1'b1; redirectPc = 32'h83;
        @(negedge clk);
        check32("redir_fv", {31'b0, fetchValid}, 32'd0);
        tick;
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("drain_fv", {31'b0, fetchValid}, 32'd0);
            check32("drain_noreq", {31'b0, imemReq}, 32'd0);
            tick;
        end
        repeat (5) tick;
        end_test("drain");

        // Redirect coinciding with imemValid, target near the top of memory (wraps).
        lat = 1;
        reset_dut;
        push_addr(32'h0); push_addr(32'hFFFF_FFFC); push_addr(32'h0);
        push_fetch(32'hFFFF_FFFC, 1'b0);
        tick;
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFE;
        @(negedge clk);
        check32("redir_valid_fv", {31'b0, fetchValid}, 32'd0);
        tick;
        redirect = 1'b0;
        @(negedge clk);
        check32("no_drain_req", {31'b0, imemReq}, 32'd1);
        tick; tick; tick;
        end_test("redir_valid");

        // Reset during FS_HOLD with a BTB entry present.
        lat = 1; pred_en = 1'b1;
        reset_dut;
        push_addr(32'h0);
        btbWe = 1'b1; btbWPc = 32'h0; btbWTarget = 32'h100;
        tick;
        btbWe = 1'b0; stall = 1'b1;
        @(negedge clk);
        check32("hold_bpred", {31'b0, bPredictedTakenF}, 32'd1);
        check32("hold_instr", instrF, mem_word(32'h0));
        tick;
        reset_dut;
        end_test("hold_pre");
        push_addr(32'h0); push_addr(32'h4);
        push_fetch(32'h0, 1'b0); push_fetch(32'h4, 1'b0);
        repeat (4) tick;
        end_test("hold_post");

        rst = 1'b1;
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
